// File: rtl/adder_32bit_pkg.sv
// Shared width and output reset values for the registered 32-bit adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    localparam logic [ADDER_WIDTH-1:0] ADDER_RST_SUM  = '0;
    localparam logic                   ADDER_RST_COUT = 1'b0;
    localparam logic                   ADDER_RST_OVF  = 1'b0;
    localparam logic                   ADDER_RST_ZERO = 1'b1;

    // Flag bundle as it leaves the output registers.
    typedef struct packed {
        logic [ADDER_WIDTH-1:0] sum;
        logic                   cout;
        logic                   ovf;
        logic                   zero;
    } adder_res_t;

    localparam adder_res_t ADDER_RST_RES = '{
        sum:  ADDER_RST_SUM,
        cout: ADDER_RST_COUT,
        ovf:  ADDER_RST_OVF,
        zero: ADDER_RST_ZERO
    };

    // Signed overflow rule for an addition of two operands into a result.
    function automatic logic adder_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_32bit_if.sv
// Operand/result bundle between an adder client and adder_32bit.
// Latency: n/a (wires only); the sub control exists only with ADDER_SUB_EN.
// Backpressure: none; no handshake, one operation accepted every cycle.
interface adder_32bit_if;
    import adder_pkg::*;

    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   cin;
`ifdef ADDER_SUB_EN
    logic                   sub;
`endif
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cout;
    logic                   ovf;
    logic                   zero;

    modport master (
        output a,
        output b,
        output cin,
`ifdef ADDER_SUB_EN
        output sub,
`endif
        input  sum,
        input  cout,
        input  ovf,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
`ifdef ADDER_SUB_EN
        input  sub,
`endif
        output sum,
        output cout,
        output ovf,
        output zero
    );

endinterface : adder_32bit_if

// File: rtl/adder_full_bit.sv
// One full-adder cell of the ripple-carry chain.
// Latency: combinational.
// Backpressure: none.
module adder_full_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : adder_full_bit

// File: rtl/adder_32bit.sv
// Registered ripple-carry adder with carry, signed-overflow and zero flags; ADDER_SUB_EN adds a subtract control.
// Latency: 1 cycle from operands to sum/cout/ovf/zero; synchronous active-high reset.
// Backpressure: none; accepts a new operation every cycle with no bubbles.
module adder_32bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    adder_32bit_if.slave  bus
);

    logic [WIDTH-1:0] b_eff;
    logic             c_in_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_raw;

    adder_res_t res_d;
    adder_res_t res_q;

    // Subtract is a + ~b + 1: the forced carry-in supplies the +1.
`ifdef ADDER_SUB_EN
    always_comb begin
        b_eff    = bus.sub ? ~bus.b : bus.b;
        c_in_eff = bus.sub ? 1'b1   : bus.cin;
    end
`else
    always_comb begin
        b_eff    = bus.b;
        c_in_eff = bus.cin;
    end
`endif

    assign carry[0] = c_in_eff;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        adder_full_bit u_fa (
            .a  (bus.a[i]),
            .b  (b_eff[i]),
            .ci (carry[i]),
            .s  (sum_raw[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        res_d      = ADDER_RST_RES;
        res_d.sum  = sum_raw;
        res_d.cout = carry[WIDTH];
        res_d.ovf  = adder_ovf(bus.a[WIDTH-1], b_eff[WIDTH-1], sum_raw[WIDTH-1]);
        res_d.zero = (sum_raw == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= ADDER_RST_RES;
        end else begin
            res_q <= res_d;
        end
    end

    assign bus.sum  = res_q.sum;
    assign bus.cout = res_q.cout;
    assign bus.ovf  = res_q.ovf;
    assign bus.zero = res_q.zero;

endmodule : adder_32bit

// File: tb/tb_adder_32bit.sv
// Scoreboard bench for adder_32bit: driver pushes expected results, monitor pops one per cycle.
module tb_adder_32bit;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    adder_32bit_if bif ();

    adder_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Reference: plain wide arithmetic on the operand values.
    function automatic exp_t model(input logic r, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci,
                                   input logic sb);
        exp_t   e;
        longint u;
        longint s;
        if (r) begin
            e.sum = 32'd0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b1;
            return e;
        end
        if (sb) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            s      = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u      = longint'(a) + longint'(b) + longint'(ci);
            e.sum  = u[31:0];
            e.cout = u[32];
            s      = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb);
        @(negedge clk);
        rst     = r;
        bif.a   = a;
        bif.b   = b;
        bif.cin = ci;
`ifdef ADDER_SUB_EN
        bif.sub = sb;
        exp_q.push_back(model(r, a, b, ci, sb));
`else
        exp_q.push_back(model(r, a, b, ci, 1'b0));
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, expv);
        end
    endtask

    // Driver
    initial begin
        bif.a   = 32'd0;
        bif.b   = 32'd0;
        bif.cin = 1'b0;
`ifdef ADDER_SUB_EN
        bif.sub = 1'b0;
`endif
        drive(1'b1, 32'd5, 32'd9, 1'b0, 1'b0);
        drive(1'b1, 32'd5, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 32'd5, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd5, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 32'd16, 32'd32, 1'b0, 1'b0);
        drive(1'b0, 32'd128, 32'd64, 1'b0, 1'b0);
        drive(1'b0, 32'hFFFF_FFC0, 32'd64, 1'b0, 1'b0);
        drive(1'b0, 32'hFFFF_FFC0, 32'd96, 1'b0, 1'b0);
        drive(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        drive(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drive(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
        // Mid-stream reset with live operands must discard them.
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        drive(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
`ifdef ADDER_SUB_EN
        drive(1'b0, 32'd10, 32'd3, 1'b0, 1'b1);
        drive(1'b0, 32'd3, 32'd10, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
        drive(1'b0, 32'd7, 32'd7, 1'b1, 1'b1);
`endif
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            case ($urandom_range(0, 3))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h8000_0000 - 32'($urandom_range(0, 2));
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? (~ra + 32'($urandom_range(0, 1))) : $urandom;
            drive(($urandom_range(0, 31) == 0), ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        done = 1'b1;
    end

    // Monitor: one result per cycle, exactly one cycle after its operands.
    initial begin
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!(done && exp_q.size() == 0) && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sum",  bif.sum, e.sum);
                chk("cout", {31'd0, bif.cout}, {31'd0, e.cout});
                chk("ovf",  {31'd0, bif.ovf},  {31'd0, e.ovf});
                chk("zero", {31'd0, bif.zero}, {31'd0, e.zero});
            end
        end
        if (cyc >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout got %0d cycles expected under 5000", cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_32bit
